// File: rtl/mem_sram_controller_pkg.sv
// rtl/mem_sram_controller_pkg.sv - shared types and constants for the memory-stage SRAM controller
package mem_sram_controller_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0] DATA_MEM_BASE_DEFAULT = 32'd1024;

endpackage

// File: rtl/mem_sram_controller.sv
// rtl/mem_sram_controller.sv - 32-bit load/store over a 16-bit async SRAM as two halfword transfers
module mem_sram_controller
  import mem_sram_controller_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter logic [31:0] DATA_MEM_BASE = DATA_MEM_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] address,
  input  logic [31:0] ST_val,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N
);

  localparam int unsigned CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          op_write;
  logic [31:0]   st_data;
  logic [17:0]   sram_addr;
  logic [31:0]   rdata;
  logic          req;
  logic          last;
  logic [31:0]   offset;
  logic          unused_offset_bits;
  logic          dq_oe;
  logic [15:0]   dq_out;

  assign req    = MEM_R_EN | MEM_W_EN;
  assign last   = (cnt == CNT_LAST);
  assign offset = address - DATA_MEM_BASE;
  // Only 17 word-index bits reach the SRAM; higher bits wrap silently.
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_write  <= 1'b0;
      st_data   <= '0;
      sram_addr <= '0;
      rdata     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req) begin
            op_write  <= MEM_W_EN;
            st_data   <= ST_val;
            sram_addr <= {offset[18:2], 1'b0};
          end
        end
        LOW: begin
          if (last) begin
            cnt          <= '0;
            sram_addr[0] <= 1'b1;
            if (!op_write) rdata[15:0] <= SRAM_DQ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (last) begin
            cnt <= '0;
            if (!op_write) rdata[31:16] <= SRAM_DQ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = LOW;
      LOW:     if (last) state_nxt = HIGH;
      HIGH:    if (last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    dq_oe     = 1'b0;
    dq_out    = st_data[15:0];
    if (state == LOW || state == HIGH) begin
      if (op_write) begin
        SRAM_WE_N = 1'b0;
        dq_oe     = 1'b1;
      end else begin
        SRAM_OE_N = 1'b0;
      end
      if (state == HIGH) dq_out = st_data[31:16];
    end
  end

  assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;
  assign SRAM_ADDR = sram_addr;
  assign read_data = rdata;
  assign ready     = ~req | (state == DONE);
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_mem_sram_controller.sv
// tb/tb_mem_sram_controller.sv - bench for mem_sram_controller with a behavioural 256Kx16 SRAM
module sram_model (
  input  logic        clk,
  input  logic [17:0] addr,
  inout  wire  [15:0] dq,
  input  logic        we_n,
  input  logic        oe_n,
  input  logic        ce_n
);
  logic [15:0] mem [0:262143];

  assign dq = (!ce_n && !oe_n && we_n) ? mem[addr] : 16'bz;

  // A write only lands once WE_N has been held low through a whole clock period.
  always @(posedge clk) begin
    if (!ce_n && !we_n) mem[addr] <= dq;
  end
endmodule

module tb_mem_sram_controller;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        re_a = 1'b0, we_a = 1'b0, re_b = 1'b0, we_b = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] stv = '0;

  logic [31:0] rd_a, rd_b;
  logic        rdy_a, rdy_b;
  wire  [15:0] dq_a, dq_b;
  logic [17:0] sa_a, sa_b;
  logic        wen_a, wen_b, oen_a, oen_b;
  logic        ce_a, ce_b, ub_a, ub_b, lb_a, lb_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_sram_controller #(.ACCESS_CYCLES(2), .DATA_MEM_BASE(32'd1024)) dut_a (
    .clk(clk), .rst(rst), .MEM_R_EN(re_a), .MEM_W_EN(we_a), .address(addr), .ST_val(stv),
    .read_data(rd_a), .ready(rdy_a), .SRAM_DQ(dq_a), .SRAM_ADDR(sa_a), .SRAM_WE_N(wen_a),
    .SRAM_OE_N(oen_a), .SRAM_CE_N(ce_a), .SRAM_UB_N(ub_a), .SRAM_LB_N(lb_a)
  );

  mem_sram_controller #(.ACCESS_CYCLES(1), .DATA_MEM_BASE(32'd1024)) dut_b (
    .clk(clk), .rst(rst), .MEM_R_EN(re_b), .MEM_W_EN(we_b), .address(addr), .ST_val(stv),
    .read_data(rd_b), .ready(rdy_b), .SRAM_DQ(dq_b), .SRAM_ADDR(sa_b), .SRAM_WE_N(wen_b),
    .SRAM_OE_N(oen_b), .SRAM_CE_N(ce_b), .SRAM_UB_N(ub_b), .SRAM_LB_N(lb_b)
  );

  sram_model u_sram_a (.clk(clk), .addr(sa_a), .dq(dq_a), .we_n(wen_a), .oe_n(oen_a), .ce_n(ce_a));
  sram_model u_sram_b (.clk(clk), .addr(sa_b), .dq(dq_b), .we_n(wen_b), .oe_n(oen_b), .ce_n(ce_b));

  typedef struct {
    bit          sel;
    bit          w;
    bit          r;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    int          exp_rdy;
    int          exp_we;
    logic [17:0] exp_lo;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] peek(input bit sel, input logic [17:0] i);
    return sel ? u_sram_b.mem[i] : u_sram_a.mem[i];
  endfunction

  task automatic run_access(input bit sel, input bit do_w, input bit do_r,
                            input logic [31:0] a, input logic [31:0] d,
                            output int rdy_cyc, output int we_cyc, output int n_act,
                            output logic [17:0] a_lo, output logic [17:0] a_hi,
                            output logic [31:0] rd);
    @(negedge clk);
    addr = a;
    stv  = d;
    if (sel) begin we_b = do_w; re_b = do_r; end
    else     begin we_a = do_w; re_a = do_r; end
    rdy_cyc = -1; we_cyc = 0; n_act = 0; a_lo = '0; a_hi = '0; rd = '0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if ((sel ? wen_b : wen_a) == 1'b0) we_cyc++;
      if ((sel ? wen_b : wen_a) == 1'b0 || (sel ? oen_b : oen_a) == 1'b0) begin
        if (n_act == 0) a_lo = sel ? sa_b : sa_a;
        a_hi = sel ? sa_b : sa_a;
        n_act++;
      end
      if (sel ? rdy_b : rdy_a) begin
        rdy_cyc = c;
        rd = sel ? rd_b : rd_a;
        break;
      end
    end
    we_a = 1'b0; re_a = 1'b0; we_b = 1'b0; re_b = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    logic dq_ok;
    dq_ok = (dq_a === 16'hzzzz) || (dq_a === 16'h0000);
    check({tag, "_ready"}, {31'd0, rdy_a}, 32'd1);
    check({tag, "_we_n"}, {31'd0, wen_a}, 32'd1);
    check({tag, "_oe_n"}, {31'd0, oen_a}, 32'd1);
    check({tag, "_dq_released"}, {31'd0, dq_ok}, 32'd1);
  endtask

  initial begin
    int rc, wc, na;
    logic [17:0] lo, hi;
    logic [31:0] rd;

    //          sel  w  r  address  data           exp read_data  rdy we  lo
    vecs[0] = '{1'b0, 1, 0, 32'd1024, 32'hDEADBEEF, 32'h00000000, 5, 4, 18'd0};
    vecs[1] = '{1'b0, 0, 1, 32'd1024, 32'h00000000, 32'hDEADBEEF, 5, 0, 18'd0};
    vecs[2] = '{1'b0, 1, 0, 32'd1028, 32'h12345678, 32'hDEADBEEF, 5, 4, 18'd2};
    vecs[3] = '{1'b0, 0, 1, 32'd1024, 32'h00000000, 32'hDEADBEEF, 5, 0, 18'd0};
    vecs[4] = '{1'b0, 0, 1, 32'd1028, 32'h00000000, 32'h12345678, 5, 0, 18'd2};
    vecs[5] = '{1'b0, 1, 0, 32'd0,    32'hA5A55A5A, 32'h12345678, 5, 4, 18'h3FE00};
    vecs[6] = '{1'b0, 0, 1, 32'd0,    32'h00000000, 32'hA5A55A5A, 5, 0, 18'h3FE00};
    vecs[7] = '{1'b1, 1, 1, 32'd1024, 32'h0BADF00D, 32'h00000000, 3, 2, 18'd0};
    vecs[8] = '{1'b1, 0, 1, 32'd1024, 32'h00000000, 32'h0BADF00D, 3, 0, 18'd0};

    repeat (3) @(negedge clk);
    #1;
    check("rst_read_data", rd_a, 32'd0);
    check("rst_sram_addr", {14'd0, sa_a}, 32'd0);
    check("rst_ties", {29'd0, ce_a, ub_a, lb_a}, 32'd0);
    check_idle("rst");
    rst = 1'b1;

    foreach (vecs[i]) begin
      run_access(vecs[i].sel, vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d, rc, wc, na, lo, hi, rd);
      check($sformatf("v%0d_ready_cycle", i), rc, vecs[i].exp_rdy);
      check($sformatf("v%0d_we_cycles", i), wc, vecs[i].exp_we);
      check($sformatf("v%0d_active_cycles", i), na, vecs[i].exp_rdy - 1);
      check($sformatf("v%0d_addr_low", i), {14'd0, lo}, {14'd0, vecs[i].exp_lo});
      check($sformatf("v%0d_addr_high", i), {14'd0, hi}, {14'd0, vecs[i].exp_lo | 18'd1});
      check($sformatf("v%0d_read_data", i), rd, vecs[i].exp_rd);
      if (vecs[i].w) begin
        check($sformatf("v%0d_mem_lo", i), {16'd0, peek(vecs[i].sel, vecs[i].exp_lo)},
              {16'd0, vecs[i].d[15:0]});
        check($sformatf("v%0d_mem_hi", i), {16'd0, peek(vecs[i].sel, vecs[i].exp_lo | 18'd1)},
              {16'd0, vecs[i].d[31:16]});
      end
    end

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      check_idle($sformatf("idle%0d", c));
    end

    // Reset lands in the first HIGH cycle of a store: the upper halfword must never commit.
    @(negedge clk);
    addr = 32'd1024;
    stv  = 32'hCAFEF00D;
    we_a = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("mid_high_addr", {14'd0, sa_a}, 32'd1);
    check("mid_high_we_n", {31'd0, wen_a}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_mid_we_n", {31'd0, wen_a}, 32'd1);
    check("rst_mid_oe_n", {31'd0, oen_a}, 32'd1);
    check("rst_mid_addr", {14'd0, sa_a}, 32'd0);
    check("rst_mid_read_data", rd_a, 32'd0);
    check("rst_mid_ready_req", {31'd0, rdy_a}, 32'd0);
    we_a = 1'b0;
    #1;
    check("rst_mid_ready_idle", {31'd0, rdy_a}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_mem_word0", {16'd0, peek(1'b0, 18'd0)}, 32'h0000F00D);
    check("rst_mid_mem_word1", {16'd0, peek(1'b0, 18'd1)}, 32'h0000DEAD);

    run_access(1'b0, 1'b0, 1'b1, 32'd1024, 32'd0, rc, wc, na, lo, hi, rd);
    check("post_rst_ready_cycle", rc, 5);
    check("post_rst_we_cycles", wc, 0);
    check("post_rst_read_data", rd, 32'hDEADF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
